// File: rtl/tl_log_pkg.sv
// Shared types for the TileLink log collector: record layout and channel encodings.
package tl_log_pkg;

    localparam int DATA_W_DEF  = 256;
    localparam int ADDR_W_DEF  = 64;
    localparam int STAMP_W_DEF = 64;

    localparam logic [7:0] CH_A = 8'd0;
    localparam logic [7:0] CH_B = 8'd1;
    localparam logic [7:0] CH_C = 8'd2;
    localparam logic [7:0] CH_D = 8'd3;
    localparam logic [7:0] CH_E = 8'd4;

    typedef struct packed {
        logic [STAMP_W_DEF-1:0] seq;
        logic [STAMP_W_DEF-1:0] stamp;
        logic [7:0]             channel;
        logic [7:0]             opcode;
        logic [7:0]             param;
        logic [7:0]             source;
        logic [7:0]             sink;
        logic [ADDR_W_DEF-1:0]  address;
        logic [DATA_W_DEF-1:0]  data;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

endpackage

// File: rtl/tl_log_fifo.sv
// Synchronous show-ahead FIFO; head visible the cycle after the write.
// Push while full is accepted only together with a pop; push otherwise ignored when full.
module tl_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/tl_log_collector.sv
// Captures monitored TileLink beats into per-channel holding slots, stamps and sequences them into a FIFO.
// Capture to out_valid is two cycles; the monitored bus is never stalled, excess beats are counted as drops.
module tl_log_collector
    import tl_log_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 16,
    parameter int STAMP_W = STAMP_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*8-1:0]      in_opcode,
    input  logic [NUM_CH*8-1:0]      in_param,
    input  logic [NUM_CH*8-1:0]      in_source,
    input  logic [NUM_CH*8-1:0]      in_sink,
    input  logic [NUM_CH*ADDR_W-1:0] in_address,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output rec_t                     out_rec,
    output logic [31:0]              drop_cnt,
    output logic                     overflow
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [STAMP_W-1:0] stamp_q;
    logic [STAMP_W-1:0] seq_q;
    logic [CH_W-1:0]    rr_q;
    logic [NUM_CH-1:0]  pend_vld_q;
    logic [NUM_CH-1:0]  pend_vld_d;
    rec_t               pend_q [NUM_CH];
    rec_t               beat   [NUM_CH];
    logic [31:0]        drop_cnt_q;
    logic               overflow_q;

    logic [NUM_CH-1:0]  capture;
    logic [NUM_CH-1:0]  drop;
    logic               gnt_vld;
    logic [CH_W-1:0]    gnt_idx;
    logic [CH_W-1:0]    c_idx;
    logic [32:0]        drop_sum;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    rec_t               fifo_din;

    assign capture  = {NUM_CH{en}} & ch_mask & in_valid;
    assign fifo_pop = !fifo_empty && out_ready;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            beat[i]         = '0;
            beat[i].stamp   = stamp_q;
            beat[i].channel = 8'(i);
            beat[i].opcode  = in_opcode[8*i +: 8];
            beat[i].param   = in_param[8*i +: 8];
            beat[i].source  = in_source[8*i +: 8];
            beat[i].sink    = in_sink[8*i +: 8];
            beat[i].address = in_address[ADDR_W*i +: ADDR_W];
            beat[i].data    = in_data[DATA_W*i +: DATA_W];
        end
    end

    // Round-robin search from rr_q; a full FIFO still accepts when it pops this cycle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        c_idx   = '0;
        if (!fifo_full || fifo_pop) begin
            for (int k = 0; k < NUM_CH; k++) begin
                c_idx = CH_W'((int'(rr_q) + k) % NUM_CH);
                if (!gnt_vld && pend_vld_q[c_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = c_idx;
                end
            end
        end
    end

    always_comb begin
        drop       = '0;
        pend_vld_d = pend_vld_q;
        for (int i = 0; i < NUM_CH; i++) begin
            drop[i] = capture[i] && pend_vld_q[i] && !(gnt_vld && gnt_idx == CH_W'(i));
            if (capture[i] && !drop[i]) begin
                pend_vld_d[i] = 1'b1;
            end else if (gnt_vld && gnt_idx == CH_W'(i)) begin
                pend_vld_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        fifo_din     = pend_q[gnt_idx];
        fifo_din.seq = seq_q;
    end

    assign drop_sum = {1'b0, drop_cnt_q} + 33'($countones(drop));

    always_ff @(posedge clock) begin
        if (reset) begin
            stamp_q    <= '0;
            seq_q      <= '0;
            rr_q       <= '0;
            pend_vld_q <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            stamp_q    <= stamp_q + STAMP_W'(1);
            pend_vld_q <= pend_vld_d;
            drop_cnt_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            if (|drop) overflow_q <= 1'b1;
            if (gnt_vld) begin
                seq_q <= seq_q + STAMP_W'(1);
                rr_q  <= (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (capture[i] && !drop[i]) pend_q[i] <= beat[i];
        end
    end

    tl_log_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .push_i  (gnt_vld),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (out_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/tl_log_collector.md
Name: tl_log_collector

Overview:
- Multi-channel TileLink transaction log collector; successor of the single-record DPI log writer.
- Captures beats from NUM_CH monitored channels and stamps each with a capture-cycle timestamp and a global sequence number.
- Buffers records in a DEPTH-entry FIFO and drains them over a valid/ready stream to the log sink (DPI shim or trace port).
- Counts drops instead of stalling the DUT; it never back-pressures the monitored bus.

Parameters:
NUM_CH, 5, number of monitored channels (channel index i reported as record channel field)
DATA_W, 256, beat data width (multiple of 64)
ADDR_W, 64, address width
DEPTH, 16, main FIFO depth (power of 2, >=2)
STAMP_W, 64, timestamp and sequence counter width

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
en  in  1  global capture enable
ch_mask  in  NUM_CH  per-channel capture enable
in_valid  in  NUM_CH  beat present on channel i (fire already qualified by valid&ready)
in_opcode  in  NUM_CH*8  per-channel opcode, channel i at [8i+:8]
in_param  in  NUM_CH*8  per-channel param
in_source  in  NUM_CH*8  per-channel source id
in_sink  in  NUM_CH*8  per-channel sink id
in_address  in  NUM_CH*ADDR_W  per-channel address
in_data  in  NUM_CH*DATA_W  per-channel beat data
out_valid  out  1  record available
out_ready  in  1  sink accepts record
out_rec  out  rec_t width  {seq, stamp, channel[7:0], opcode, param, source, sink, address, data}
drop_cnt  out  32  saturating count of dropped beats
overflow  out  1  sticky: at least one drop since reset

Behaviour:
- Reset: out_valid=0, drop_cnt=0, overflow=0, stamp counter=0, seq counter=0, FIFO empty, pending regs empty, RR pointer=0.
- Stamp counter increments every cycle after reset, wrapping at 2^STAMP_W.
- Capture: channel i captures when en && ch_mask[i] && in_valid[i].
  - The beat is stored in pending[i] together with the current stamp.
  - Each channel has a 1-deep pending register.
- Drop: a capture is dropped when pending[i] is full and not being transferred in the same cycle.
  - pending[i] keeps its old contents.
  - drop_cnt += 1 per dropped channel per cycle (several channels may drop in one cycle; add popcount).
  - drop_cnt saturates at 0xFFFFFFFF.
  - overflow sets and stays set until reset.
- Transfer: round-robin arbiter picks at most one full pending[i] per cycle when the FIFO is not full, or is full and being popped this cycle.
  - Search starts at the RR pointer; after a grant to channel g, pointer = (g+1) mod NUM_CH.
  - If the granted channel also captures in the same cycle, pending[g] reloads with the new beat, and no drop is counted.
- Sequence number:
  - Assigned at FIFO write, not at capture; seq counter increments per write and wraps.
  - FIFO order therefore equals seq order.
  - Stamps are monotonic per channel only.
- Latency: a capture in cycle N, with empty pending/FIFO and the channel granted, gives out_valid in cycle N+2 (N+1 pending, N+2 FIFO head).
- Output: out_rec is driven from the FIFO head and is stable while out_valid && !out_ready.
  - Pop occurs on out_valid && out_ready.
  - Simultaneous push and pop when full is legal: occupancy unchanged.
- Pointer wrap: FIFO read/write pointers are log2(DEPTH)+1 bits; full when the MSBs differ and the LSBs are equal.
- en deassertion: blocks new captures only; pending entries and FIFO contents still drain.
- Mid-operation reset: all buffered records discarded, with no output during reset.
  - In the first cycle after reset, stamp reads 0 for captures.

Decomposition:
- Package tl_log_pkg holds:
  - rec_t packed struct
  - channel encoding constants CH_A=0, CH_B=1, CH_C=2, CH_D=3, CH_E=4
  - localparam REC_W
- Sub-module tl_log_fifo (parameters WIDTH, DEPTH): synchronous FIFO with push/pop/full/empty, show-ahead head, and legal push+pop when full.

Test Plan:
- Single beat on ch 2 (opcode 4, addr 0x80001000) at stamp 10, out_ready=1 -> one record at cycle 12 with channel=2, stamp=10, seq=0.
- All 5 channels valid in one cycle, FIFO empty -> 5 records in 5 consecutive cycles, channel order 0,1,2,3,4, seq 0..4, identical stamps, drop_cnt=0.
- out_ready=0, ch 0 valid every cycle for 20 cycles, DEPTH=16 -> 16 FIFO + 1 pending held, drop_cnt=3, overflow=1; then out_ready=1 -> 17 records in seq order.
- ch_mask=5'b00010 with all channels valid -> only channel 1 logged; en=0 -> nothing logged, drop_cnt unchanged.
- Reset asserted with 8 records buffered -> out_valid=0 next cycle; drop_cnt=0; first post-reset record has seq=0.
- Full FIFO with out_ready=1 and a continuous capture on one channel -> steady 1 record/cycle throughput, no drops.
